// File: rtl/observer_hex_formatter.sv
// Turns one DW-bit sample into ASCII hex text for the UART: the digits go out MSB nibble first,
// followed by a space, or by CR LF when the sample closes a record.
module observer_hex_formatter #(
  parameter int DW        = 16,
  parameter int UPPERCASE = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_data,
  input  logic          i_last,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready
);

  localparam int NIB = DW / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [2:0] {IDLE, DIGIT, SEP, CR, LF} state_t;

  state_t                 state;
  logic signed [DW-1:0]   data_p0;
  logic                   last_p0;
  logic        [IW-1:0]   idx_p0;
  logic                   tx_hs;

  assign tx_hs = o_tx_valid && i_tx_ready;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return ((UPPERCASE != 0) ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [3:0] nibble_at(input logic [DW-1:0] d, input logic [IW-1:0] i);
    logic [DW-1:0] sh;
    sh = d >> {i, 2'b00};
    return sh[3:0];
  endfunction

  // Capture stage: sample/flag frozen from acceptance until the terminator leaves
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      data_p0    <= '0;
      last_p0    <= 1'b0;
      idx_p0     <= '0;
      o_ready    <= 1'b0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          o_ready <= 1'b1;
          if (i_valid && o_ready) begin
            data_p0    <= i_data;
            last_p0    <= i_last;
            idx_p0     <= IW'(NIB - 1);
            o_ready    <= 1'b0;
            o_tx_valid <= 1'b1;
            o_tx_data  <= hex_ascii(i_data[DW-1 -: 4]);
            state      <= DIGIT;
          end
        end
        DIGIT: begin
          if (tx_hs) begin
            if (idx_p0 == '0) begin
              o_tx_data <= last_p0 ? 8'h0D : 8'h20;
              state     <= last_p0 ? CR : SEP;
            end else begin
              idx_p0    <= idx_p0 - IW'(1);
              o_tx_data <= hex_ascii(nibble_at(data_p0, idx_p0 - IW'(1)));
            end
          end
        end
        CR: begin
          if (tx_hs) begin
            o_tx_data <= 8'h0A;
            state     <= LF;
          end
        end
        SEP, LF: begin
          if (tx_hs) begin
            o_tx_valid <= 1'b0;
            o_ready    <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_observer_hex_formatter.sv
// Directed bench for observer_hex_formatter: an uppercase and a lowercase instance share clock and reset.
module tb_observer_hex_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_a, data_b;
  logic        last_a, last_b, valid_a, valid_b, txr_a, txr_b;
  logic        ready_a, ready_b, txv_a, txv_b;
  logic [7:0]  txd_a, txd_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  observer_hex_formatter #(.DW(16), .UPPERCASE(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data_a), .i_last(last_a), .i_valid(valid_a),
    .o_ready(ready_a), .o_tx_data(txd_a), .o_tx_valid(txv_a), .i_tx_ready(txr_a));

  observer_hex_formatter #(.DW(16), .UPPERCASE(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data_b), .i_last(last_b), .i_valid(valid_b),
    .o_ready(ready_b), .o_tx_data(txd_b), .o_tx_valid(txv_b), .i_tx_ready(txr_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Check the byte currently presented by instance a or b, then advance one clock.
  task automatic expect_byte(input string tag, input bit inst_b, input logic [7:0] b);
    if (inst_b) begin
      chk({tag, "_valid"}, {31'd0, txv_b}, 32'd1);
      chk(tag, {24'd0, txd_b}, {24'd0, b});
    end else begin
      chk({tag, "_valid"}, {31'd0, txv_a}, 32'd1);
      chk(tag, {24'd0, txd_a}, {24'd0, b});
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    data_a = '0; last_a = 0; valid_a = 0; txr_a = 1;
    data_b = '0; last_b = 0; valid_b = 0; txr_b = 1;

    // Reset hold
    tick(); tick(); tick();
    chk("rst_txv", {31'd0, txv_a}, 32'd0);
    chk("rst_txd", {24'd0, txd_a}, 32'h00);
    chk("rst_ready", {31'd0, ready_a}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", {31'd0, ready_a}, 32'd1);
    chk("rel_txv", {31'd0, txv_a}, 32'd0);

    // Basic sample 0x1A2F
    data_a = 16'h1A2F; last_a = 0; valid_a = 1;
    tick();
    valid_a = 0;
    chk("basic_ready_low", {31'd0, ready_a}, 32'd0);
    expect_byte("basic_d3", 0, 8'h31);
    expect_byte("basic_d2", 0, 8'h41);
    expect_byte("basic_d1", 0, 8'h32);
    expect_byte("basic_d0", 0, 8'h46);
    expect_byte("basic_sep", 0, 8'h20);
    chk("basic_end_txv", {31'd0, txv_a}, 32'd0);
    chk("basic_end_ready", {31'd0, ready_a}, 32'd1);

    // Lowercase last sample 0xBEEF
    data_b = 16'hBEEF; last_b = 1; valid_b = 1;
    tick();
    valid_b = 0;
    expect_byte("lc_d3", 1, 8'h62);
    expect_byte("lc_d2", 1, 8'h65);
    expect_byte("lc_d1", 1, 8'h65);
    expect_byte("lc_d0", 1, 8'h66);
    expect_byte("lc_cr", 1, 8'h0D);
    expect_byte("lc_lf", 1, 8'h0A);
    chk("lc_end_txv", {31'd0, txv_b}, 32'd0);
    chk("lc_end_ready", {31'd0, ready_b}, 32'd1);

    // Backpressure on second digit, with input change mid-stream
    txr_a = 0;
    tick();
    chk("idle_txready_ignored", {31'd0, txv_a}, 32'd0);
    txr_a = 1;
    data_a = 16'h0009; last_a = 0; valid_a = 1;
    tick();
    valid_a = 0; data_a = 16'hFFFF;
    expect_byte("bp_d3", 0, 8'h30);
    txr_a = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_txv", {31'd0, txv_a}, 32'd1);
      chk("bp_hold_txd", {24'd0, txd_a}, 32'h30);
    end
    txr_a = 1;
    expect_byte("bp_d2", 0, 8'h30);
    expect_byte("bp_d1", 0, 8'h30);
    expect_byte("bp_d0", 0, 8'h39);
    expect_byte("bp_sep", 0, 8'h20);
    chk("bp_end_txv", {31'd0, txv_a}, 32'd0);

    // Back-to-back with i_valid held high
    data_a = 16'h0000; last_a = 0; valid_a = 1;
    tick();
    data_a = 16'hFFFF; last_a = 1;
    expect_byte("b2b_a3", 0, 8'h30);
    expect_byte("b2b_a2", 0, 8'h30);
    expect_byte("b2b_a1", 0, 8'h30);
    expect_byte("b2b_a0", 0, 8'h30);
    expect_byte("b2b_asep", 0, 8'h20);
    chk("b2b_gap_txv", {31'd0, txv_a}, 32'd0);
    chk("b2b_gap_ready", {31'd0, ready_a}, 32'd1);
    tick();
    valid_a = 0;
    expect_byte("b2b_b3", 0, 8'h46);
    expect_byte("b2b_b2", 0, 8'h46);
    expect_byte("b2b_b1", 0, 8'h46);
    expect_byte("b2b_b0", 0, 8'h46);
    expect_byte("b2b_cr", 0, 8'h0D);
    expect_byte("b2b_lf", 0, 8'h0A);
    chk("b2b_end_txv", {31'd0, txv_a}, 32'd0);

    // Mid-sample reset
    data_a = 16'h1234; last_a = 0; valid_a = 1;
    tick();
    valid_a = 0;
    expect_byte("mr_d3", 0, 8'h31);
    expect_byte("mr_d2", 0, 8'h32);
    rst_n = 1'b0;
    tick();
    chk("mr_txv", {31'd0, txv_a}, 32'd0);
    chk("mr_txd", {24'd0, txd_a}, 32'h00);
    chk("mr_ready", {31'd0, ready_a}, 32'd0);
    tick();
    chk("mr_txv2", {31'd0, txv_a}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mr_rel_txv", {31'd0, txv_a}, 32'd0);
    chk("mr_rel_ready", {31'd0, ready_a}, 32'd1);
    data_a = 16'h5678; last_a = 0; valid_a = 1;
    tick();
    valid_a = 0;
    expect_byte("mr_n3", 0, 8'h35);
    expect_byte("mr_n2", 0, 8'h36);
    expect_byte("mr_n1", 0, 8'h37);
    expect_byte("mr_n0", 0, 8'h38);
    expect_byte("mr_nsep", 0, 8'h20);
    chk("mr_end_txv", {31'd0, txv_a}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
